// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame bit indices,
// default timing and common keyboard command bytes.
package ps2_pkg;

    // Host-to-device transmit FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StSend,
        StWaitIdle
    } ps2_tx_state_e;

    // Frame positions counted in device falling edges after the start bit.
    localparam int unsigned BIT_PARITY = 9;
    localparam int unsigned BIT_STOP   = 10;
    localparam int unsigned BIT_ACK    = 11;

    // Default timing at a 50 MHz system clock.
    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;    // 100 us
    localparam int unsigned DEF_SETUP_CYCLES   = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;  // 15 ms
    localparam int unsigned DEF_CNT_W          = 20;

    // Keyboard command bytes.
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // PS/2 uses odd parity: data bits plus parity bit carry an odd count of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pad plus falling-edge detect.
// Shared with the PS/2 receive path.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one byte using the request-to-send
// sequence, driving the shared pads through open-drain enables.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts a
// transfer when the device stops clocking.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic       OSCCLK,
    input  logic       RESET_N,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             ack_ok_q, ack_ok_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             clk_oe, data_oe;
    logic             send_oe;

    logic clk_sync, clk_fe;
    logic data_sync;
    logic unused_data_fe;

    ps2_line_sync u_clk_sync (
        .clk_i  (OSCCLK),
        .rst_ni (RESET_N),
        .line_i (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clk_i  (OSCCLK),
        .rst_ni (RESET_N),
        .line_i (ps2_data_in),
        .sync_o (data_sync),
        .fall_o (unused_data_fe)
    );

`ifdef PS2_TX_TIMEOUT_EN
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             wdog_expired;

    assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter register.
    always_ff @(posedge OSCCLK) begin
        if (!RESET_N) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Line level to present in SEND: start bit, data LSB first, parity, then release.
    always_comb begin
        send_oe = 1'b0;
        if (bitcnt_q == 4'd0) begin
            send_oe = 1'b1;
        end else if (bitcnt_q <= 4'd8) begin
            send_oe = ~data_q[bitcnt_q[2:0] - 3'd1];
        end else if (bitcnt_q == 4'(BIT_PARITY)) begin
            send_oe = ~parity_q;
        end
    end

    // Next-state and pad-enable decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        parity_d = parity_q;
        ack_ok_d = ack_ok_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        clk_oe   = 1'b0;
        data_oe  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wdog_d   = wdog_q;
`endif

        unique case (state_q)
            StIdle: begin
                bitcnt_d = '0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    cnt_d    = '0;
                    state_d  = StInhibit;
                end
            end

            StInhibit: begin
                clk_oe = 1'b1;
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStart: begin
                clk_oe  = 1'b1;
                data_oe = 1'b1;
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    state_d  = StSend;
`ifdef PS2_TX_TIMEOUT_EN
                    wdog_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StSend: begin
                data_oe = send_oe;
                if (clk_fe) begin
                    if (bitcnt_q == 4'(BIT_STOP)) begin
                        // Device pulls data low during the 11th clock to acknowledge.
                        ack_ok_d = ~data_sync;
                        bitcnt_d = 4'(BIT_ACK);
                        state_d  = StWaitIdle;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
`ifdef PS2_TX_TIMEOUT_EN
                    wdog_d = '0;
                end else if (wdog_expired) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end

            StWaitIdle: begin
                if (clk_sync && data_sync) begin
                    done_d  = ack_ok_q;
                    error_d = ~ack_ok_q;
                    state_d = StIdle;
`ifdef PS2_TX_TIMEOUT_EN
                end else if (clk_fe) begin
                    wdog_d = '0;
                end else if (wdog_expired) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge OSCCLK) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            ack_ok_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            ack_ok_q <= ack_ok_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Pulses are registered so they land in the first IDLE cycle, alongside tx_ready.
    assign tx_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe;
    assign ps2_data_oe = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an emulated PS/2 keyboard.
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int SET = 16;
    localparam int TMO = 1000;

    logic       OSCCLK = 1'b0;
    logic       RESET_N;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Device-side bookkeeping shared with the reference model.
    int fall_cyc [0:11];
    int n_falls  = 0;
    int rel_cyc  = -1;
    bit dev_ack  = 1'b0;

    // Reference model state.
    bit         chk_en      = 1'b0;
    bit         m_busy      = 1'b0;
    bit         rst_was_low = 1'b0;
    int         acc         = 0;
    logic [7:0] m_byte      = '0;
    int         done_cnt    = 0;
    int         err_cnt     = 0;

    always #5 OSCCLK = ~OSCCLK;
    always @(posedge OSCCLK) cyc <= cyc + 1;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (20)
    ) dut (
        .OSCCLK      (OSCCLK),
        .RESET_N     (RESET_N),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge OSCCLK);
        #1;
    endtask

    // Data enable the host must present after k device falling edges.
    function automatic logic exp_line(input int k, input logic [7:0] b);
        if (k == 0) return 1'b1;
        if (k <= 8) return ~b[k-1];
        if (k == 9) return ^b;  // parity bit is ~^b; a 0 bit means drive low
        return 1'b0;
    endfunction

    // Per-cycle comparison of every DUT output against the protocol timeline.
    always @(negedge OSCCLK) begin
        if (chk_en) begin
            logic e_clk, e_dat, e_rdy, e_done, e_err;
            int   d, k;
            bit   fin;
            e_clk = 1'b0; e_dat = 1'b0; e_rdy = 1'b1; e_done = 1'b0; e_err = 1'b0;
            if (rst_was_low) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                d   = cyc - acc;
                fin = 1'b0;
                if (rel_cyc >= 0 && cyc == rel_cyc + 3) begin
                    fin = 1'b1; e_done = dev_ack; e_err = !dev_ack;
                end
`ifdef PS2_TX_TIMEOUT_EN
                if (n_falls == 0 && d == INH + SET + TMO) begin
                    fin = 1'b1; e_err = 1'b1;
                end
`endif
                if (fin) begin
                    m_busy = 1'b0;
                end else begin
                    e_rdy = 1'b0;
                    if (d < INH) begin
                        e_clk = 1'b1;
                    end else if (d < INH + SET) begin
                        e_clk = 1'b1; e_dat = 1'b1;
                    end else begin
                        k = 0;
                        for (int j = 0; j < n_falls; j++) if (fall_cyc[j] + 3 <= cyc) k++;
                        e_dat = exp_line(k, m_byte);
                    end
                end
            end
            check("outputs {clk_oe,data_oe,rdy,busy,done,err}",
                  {26'd0, ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, error},
                  {26'd0, e_clk, e_dat, e_rdy, !e_rdy, e_done, e_err});
            if (done)  done_cnt++;
            if (error) err_cnt++;
            if (!m_busy && tx_valid && RESET_N) begin
                m_busy = 1'b1; acc = cyc + 1; m_byte = tx_data;
            end
            rst_was_low = !RESET_N;
        end
    end

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int t = 0; t < 10 && !busy; t++) tick(1);
        check("accept", busy, 1'b1);
    endtask

    // Keyboard: n_clk clock pulses of 20 low / 20 high cycles, sampling on rising edges.
    task automatic dev_run(input int n_clk, input bit ack, output logic [9:0] got,
                           output logic start_ok);
        got = '0; n_falls = 0; rel_cyc = -1; dev_ack = ack; start_ok = 1'b0;
        for (int t = 0; t < 6000 && !(ps2_data_oe && !ps2_clk_oe); t++) tick(1);
        check("request-to-send seen", ps2_data_oe && !ps2_clk_oe, 1'b1);
        tick(10);
        start_ok = !ps2_data_in;
        for (int i = 1; i <= n_clk; i++) begin
            dev_clk = 1'b0; fall_cyc[i-1] = cyc; n_falls = i;
            tick(20);
            if (i <= 10) got[i-1] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 11) begin dev_data = 1'b1; rel_cyc = cyc; end
            if (i == 10 && ack) begin tick(5); dev_data = 1'b0; tick(15); end
            else tick(20);
        end
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        tick(1);
        RESET_N = 1'b1;
    endtask

    initial begin
        logic [9:0] got;
        logic       sb;
        int         inh, st, d0, e0;
        RESET_N = 1'b0; tx_valid = 1'b0; tx_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
        tick(3);
        RESET_N = 1'b1;
        chk_en  = 1'b1;

        // Idle after reset.
        tick(100);
        check("idle tx_ready", tx_ready, 1'b1);
        check("idle busy", busy, 1'b0);
        check("idle clk_oe", ps2_clk_oe, 1'b0);
        check("idle data_oe", ps2_data_oe, 1'b0);

        // 0xED with acknowledge; measure inhibit and setup lengths.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        tx_valid = 1'b0;
        inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 10000) begin inh++; tick(1); end
        st = 0;
        while (ps2_clk_oe && ps2_data_oe && st < 1000) begin st++; tick(1); end
        check("inhibit length", inh, 5000);
        check("setup length", st, 16);
        dev_run(11, 1'b1, got, sb);
        check("0xED start bit low", sb, 1'b1);
        check("0xED frame {stop,par,data}", got, 10'h3ED);
        check("0xED done pulses", done_cnt - d0, 1);
        check("0xED error pulses", err_cnt - e0, 0);
        check("0xED tx_ready after", tx_ready, 1'b1);

        // 0x02 without acknowledge.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h02);
        tx_valid = 1'b0;
        dev_run(11, 1'b0, got, sb);
        check("0x02 frame {stop,par,data}", got, 10'h202);
        check("0x02 done pulses", done_cnt - d0, 0);
        check("0x02 error pulses", err_cnt - e0, 1);
        check("0x02 tx_ready after", tx_ready, 1'b1);

        // tx_valid held: 0xFF goes out, 0x00 waits for tx_ready.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(CMD_FF());
        tx_data = 8'h00;
        dev_run(11, 1'b1, got, sb);
        check("0xFF frame {stop,par,data}", got, 10'h3FF);
        check("0xFF done pulses", done_cnt - d0, 1);
        check("second byte accepted", busy, 1'b1);
        tx_valid = 1'b0;
        dev_run(11, 1'b1, got, sb);
        check("0x00 frame {stop,par,data}", got, 10'h300);
        check("0xFF+0x00 done pulses", done_cnt - d0, 2);
        check("0xFF+0x00 error pulses", err_cnt - e0, 0);

        // Reset after the 5th device falling edge.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hA5);
        tx_valid = 1'b0;
        dev_run(5, 1'b1, got, sb);
        check("0xA5 first five bits", got[4:0], 5'h05);
        pulse_reset();
        check("reset clk_oe", ps2_clk_oe, 1'b0);
        check("reset data_oe", ps2_data_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset tx_ready", tx_ready, 1'b1);
        tick(50);
        check("reset no done", done_cnt - d0, 0);
        check("reset no error", err_cnt - e0, 0);

        // No device clocking at all.
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h55);
        tx_valid = 1'b0;
        n_falls = 0; rel_cyc = -1;
        for (int t = 0; t < 6000 && !(ps2_data_oe && !ps2_clk_oe); t++) tick(1);
        check("send entered", ps2_data_oe && !ps2_clk_oe, 1'b1);
`ifdef PS2_TX_TIMEOUT_EN
        tick(TMO - 1);
        check("no early timeout", err_cnt - e0, 0);
        tick(1);
        check("timeout error", error, 1'b1);
        check("timeout release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("timeout tx_ready", tx_ready, 1'b1);
`else
        tick(TMO + 200);
        check("no timeout busy", busy, 1'b1);
        check("no timeout error", err_cnt - e0, 0);
        pulse_reset();
`endif
        tick(5);
        check("final done pulses", done_cnt - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [7:0] CMD_FF();
        return 8'hFF;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the other direction of the keyboard receive path on the LX9 board.
- It sends one command byte to the keyboard (e.g. 0xED LED-set plus its argument, 0xFF reset) using the PS/2 host request-to-send sequence.
- It drives the shared ps2_clk/ps2_data pins through open-drain enables and reports completion or error.
- It sits beside the PS/2 receiver under demo_root. The pad tristates live in the board top.

Parameters:
- INHIBIT_CYCLES, 5000: OSCCLK cycles that ps2_clk is held low before the request (100 us at 50 MHz).
- SETUP_CYCLES, 16: cycles that clock and data are both held low before clock release.
- TIMEOUT_CYCLES, 750000: watchdog limit in cycles without a device falling edge (15 ms). Used only with PS2_TX_TIMEOUT_EN.
- CNT_W, 20: timer width. Must satisfy 2^CNT_W > max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- OSCCLK  in  1  system clock, single domain.
- RESET_N  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  send request; accepted when tx_valid & tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: device acknowledged.
- error  out  1  one-cycle pulse: missing ack or timeout.
- ps2_clk_in  in  1  raw pad value, asynchronous.
- ps2_data_in  in  1  raw pad value, asynchronous.
- ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release.
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release.

Behaviour:
- Clocking and reset
  - One clock (OSCCLK). Reset is synchronous and active-low (RESET_N sampled on the OSCCLK rising edge).
  - Reset values: state IDLE, tx_ready=1, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_data_oe=0, all counters 0.
- Input sync: both pad inputs go through a 2-FF synchronizer. A falling edge (fe) is sync_prev=1 & sync=0, giving 3 cycles of detection latency.
- Accept: on tx_valid & tx_ready, latch tx_data and parity = ~^tx_data (odd parity). Go to INHIBIT; tx_ready drops the next cycle.
- States:
  - IDLE: both oe=0.
  - INHIBIT: clk_oe=1, data_oe=0, for INHIBIT_CYCLES cycles, then go to START.
  - START: clk_oe=1, data_oe=1, for SETUP_CYCLES cycles, then go to SEND.
  - SEND: clk_oe=0, data_oe=1 (start bit), bitcnt=0. Each fe increments bitcnt:
    - bitcnt 1..8: data_oe = ~tx_data[bitcnt-1], LSB first.
    - bitcnt 9: data_oe = ~parity.
    - bitcnt 10: data_oe=0 (stop bit = released line).
    - bitcnt 11: sample synced data. 0 goes to WAIT_IDLE with ack_ok=1; 1 goes to WAIT_IDLE with ack_ok=0.
  - WAIT_IDLE: both oe=0. Wait until synced clk=1 and data=1 for the same cycle. Then pulse done if ack_ok, else pulse error, and go to IDLE.
- Pulse rules: done and error are never asserted together. They fire in the same cycle that tx_ready rises.
- tx_valid while busy is ignored and the byte is not queued.
- RESET_N low in any state: both oe lines are released on the next edge, the FSM returns to IDLE, and no done/error pulse is produced.
- Pad-level glitches shorter than 2 cycles are not filtered; the device guarantees 30-50 us clock phases.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on entry to SEND and on every fe.
  - Reaching TIMEOUT_CYCLES in SEND or WAIT_IDLE forces both oe=0, pulses error and returns to IDLE.
  - This covers no keyboard attached.
- Without the macro: no watchdog, and the FSM waits indefinitely. The TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE, INHIBIT, START, SEND, WAIT_IDLE).
  - Bit-index constants: BIT_PARITY=9, BIT_STOP=10, BIT_ACK=11.
  - Default timing constants.
  - Command byte constants (CMD_SET_LED=8'hED, CMD_RESET=8'hFF).
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detect for one line. It is instantiated twice here and is reused by the PS/2 receiver.

Test Plan:
- Reset release with tx_valid=0 -> tx_ready=1, busy=0, both oe=0, indefinitely.
- Send 0xED, device model ACKs -> clk_oe low for exactly 5000 cycles, then START for 16 cycles.
  - Device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - Model drives data low at the 11th fe -> single done pulse, no error.
- Send 0x02 -> device samples parity 0. Model withholds ack (data high at 11th fe) -> single error pulse, no done, tx_ready returns high.
- tx_valid held high with 0xFF then 0x00 across the whole transfer -> only 0xFF is sent. The second byte is accepted only after tx_ready returns high, with parity 1 for both bytes.
- RESET_N pulsed low after the 5th fe -> both oe=0 on the next cycle, state IDLE, no done/error.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, no device clocking -> error pulses exactly 1000 cycles after entering SEND, lines released.
  - Without the macro, same stimulus -> busy stays high.
